// File: rtl/timer_irq_unit_pkg.sv
// Shared constants for the interval timer: register offsets within the 16-byte
// window and the TCON bit positions. The exception handler and the bus read mux
// use the same definitions.
package timer_irq_unit_pkg;

  localparam logic [3:0] OFF_TH    = 4'h0;
  localparam logic [3:0] OFF_TL    = 4'h4;
  localparam logic [3:0] OFF_TCON  = 4'h8;
  localparam logic [3:0] OFF_PRESC = 4'hC;

  localparam int unsigned TCON_EN = 0;  // count enable
  localparam int unsigned TCON_IE = 1;  // irq enable
  localparam int unsigned TCON_ST = 2;  // irq status

  typedef enum logic [1:0] {
    RegTh,
    RegTl,
    RegTcon,
    RegPresc
  } reg_sel_e;

  // Byte-lane bits are ignored, so every word in the window maps to a register.
  function automatic reg_sel_e decode_off(input logic [3:0] off);
    logic [3:0] word_off;
    reg_sel_e   sel;
    word_off = {off[3:2], 2'b00};
    sel      = RegTh;
    case (word_off)
      OFF_TL:    sel = RegTl;
      OFF_TCON:  sel = RegTcon;
      OFF_PRESC: sel = RegPresc;
      default:   sel = RegTh;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/timer_irq_unit_if.sv
// Data-memory bus as seen by the timer peripheral.
//   addr   byte address            wdata  store data
//   MemWr  store strobe            MemRd  load strobe
//   rdata  load data (comb)        hit    address falls in the timer window
// master: the CPU side driving the bus; slave: the timer.
interface timer_irq_unit_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemWr;
  logic        MemRd;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output addr, wdata, MemWr, MemRd,
    input  rdata, hit
  );

  modport slave (
    input  addr, wdata, MemWr, MemRd,
    output rdata, hit
  );
endinterface

// File: rtl/timer_prescaler.sv
// Tick divider for the interval timer. Produces one tick every presc+1 cycles
// while enabled.
//   clk    system clock           reset  async active-low reset
//   en     count enable; pc held at 0 while low
//   clr    clears pc (PRESC is being rewritten)
//   presc  divider value          tick   one-cycle strobe when pc == presc
module timer_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pc_q, pc_d;

  assign tick = en && (pc_q == presc);

  always_comb begin
    pc_d = pc_q + PRESC_W'(1);
    if (!en || clr || tick) begin
      pc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/timer_irq_unit.sv
// Memory-mapped interval timer raising IRQsig toward the control unit.
// Registers: TH reload value, TL counter, TCON {status, irq enable, count enable},
// PRESC tick divider.
//   clk     system clock
//   reset   async active-low reset
//   bus     data-memory bus (slave side): addr, wdata, MemWr, MemRd, rdata, hit
//   IRQsig  registered interrupt request, held until status or enable is cleared
module timer_irq_unit
  import timer_irq_unit_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  timer_irq_unit_if.slave   bus,
  output logic              IRQsig
);

  logic [31:0]        th_q, th_d;
  logic [31:0]        tl_q, tl_d;
  logic [2:0]         tcon_q, tcon_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               irq_q;

  reg_sel_e sel;
  logic     hit;
  logic     wr_th, wr_tl, wr_tcon, wr_presc;
  logic     tick, ovf;
  logic     unused_addr;

  assign unused_addr = ^bus.addr[1:0];

  assign hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign sel      = decode_off(bus.addr[3:0]);
  assign wr_th    = bus.MemWr && hit && (sel == RegTh);
  assign wr_tl    = bus.MemWr && hit && (sel == RegTl);
  assign wr_tcon  = bus.MemWr && hit && (sel == RegTcon);
  assign wr_presc = bus.MemWr && hit && (sel == RegPresc);

  timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (tcon_q[TCON_EN]),
    .clr  (wr_presc),
    .presc(presc_q),
    .tick (tick)
  );

  // A software store to TL on the same edge suppresses both increment and overflow.
  assign ovf = tick && (tl_q == 32'hFFFF_FFFF) && !wr_tl;

  always_comb begin
    th_d    = wr_th ? bus.wdata : th_q;
    presc_d = wr_presc ? bus.wdata[PRESC_W-1:0] : presc_q;

    tl_d = tl_q;
    if (wr_tl) begin
      tl_d = bus.wdata;
    end else if (ovf) begin
      tl_d = th_q;  // old TH, even if TH is written this edge
    end else if (tick) begin
      tl_d = tl_q + 32'd1;
    end

    // Hardware set of the status bit wins over a software write, gated by the
    // enable value that will be in effect after this edge.
    tcon_d = tcon_q;
    if (wr_tcon) begin
      tcon_d = bus.wdata[2:0];
    end
    if (ovf && tcon_d[TCON_IE]) begin
      tcon_d[TCON_ST] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q    <= '0;
      tl_q    <= '0;
      tcon_q  <= '0;
      presc_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      tcon_q  <= tcon_d;
      presc_q <= presc_d;
      irq_q   <= tcon_d[TCON_IE] & tcon_d[TCON_ST];
    end
  end

  assign IRQsig = irq_q;

  always_comb begin
    bus.rdata = '0;
    if (bus.MemRd && hit) begin
      case (sel)
        RegTh:    bus.rdata = th_q;
        RegTl:    bus.rdata = tl_q;
        RegTcon:  bus.rdata = 32'(tcon_q);
        RegPresc: bus.rdata = 32'(presc_q);
        default:  bus.rdata = '0;
      endcase
    end
  end

  assign bus.hit = hit;

endmodule

// File: tb/tb_timer_irq_unit.sv
// Self-checking bench for timer_irq_unit: a table of bus accesses with expected
// rdata/hit, followed by directed multi-cycle sequences.
module tb_timer_irq_unit;

  localparam logic [31:0] A_TH    = 32'h4000_0000;
  localparam logic [31:0] A_TL    = 32'h4000_0004;
  localparam logic [31:0] A_TCON  = 32'h4000_0008;
  localparam logic [31:0] A_PRESC = 32'h4000_000C;

  logic clk;
  logic reset;
  logic IRQsig;
  int   vecs;
  int   fails;

  timer_irq_unit_if bus ();

  timer_irq_unit #(
    .BASE_ADDR(32'h4000_0000),
    .PRESC_W  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQsig(IRQsig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Tasks start and end just after a rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.MemWr = 1'b1;
    @(posedge clk);
    #1;
    bus.MemWr = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr  = a;
    bus.MemRd = 1'b1;
    #1;
    chk(name, bus.rdata, exp);
    bus.MemRd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs      = 0;
    fails     = 0;
    reset     = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.MemWr = 1'b0;
    bus.MemRd = 1'b0;

    //         addr           wdata          wr    rd    exp_rdata      exp_hit
    tbl[0]  = '{A_TH,         32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
    tbl[1]  = '{A_TH,         32'h1234_5678, 1'b1, 1'b0, 32'h0,         1'b1};
    tbl[2]  = '{A_TH,         32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b1};
    tbl[3]  = '{A_TH,         32'h0,         1'b0, 1'b0, 32'h0,         1'b1};
    tbl[4]  = '{A_PRESC,      32'h0000_01AB, 1'b1, 1'b0, 32'h0,         1'b1};
    tbl[5]  = '{A_PRESC,      32'h0,         1'b0, 1'b1, 32'h0000_00AB, 1'b1};
    tbl[6]  = '{A_TCON,       32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0,         1'b1};
    tbl[7]  = '{A_TCON,       32'h0,         1'b0, 1'b1, 32'h0000_0006, 1'b1};
    tbl[8]  = '{32'h4000_000B, 32'h0,        1'b0, 1'b1, 32'h0000_0006, 1'b1};
    tbl[9]  = '{32'h4000_0010, 32'h0,        1'b0, 1'b1, 32'h0,         1'b0};
    tbl[10] = '{32'h4000_0006, 32'hCAFE_0000, 1'b1, 1'b0, 32'h0,        1'b1};
    tbl[11] = '{A_TL,         32'h0,         1'b0, 1'b1, 32'hCAFE_0000, 1'b1};
    tbl[12] = '{32'h3FFF_FFFC, 32'h0,        1'b0, 1'b1, 32'h0,         1'b0};
    tbl[13] = '{32'h4000_0010, 32'h0000_DEAD, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[14] = '{A_TH,         32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b1};
    tbl[15] = '{A_TCON,       32'h0,         1'b1, 1'b0, 32'h0,         1'b1};
    tbl[16] = '{A_TCON,       32'h0,         1'b0, 1'b1, 32'h0,         1'b1};

    #12 reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_irq", 32'(IRQsig), 32'h0);
    chk_rd("rst_th", A_TH, 32'h0);
    chk_rd("rst_tl", A_TL, 32'h0);
    chk_rd("rst_tcon", A_TCON, 32'h0);
    chk_rd("rst_presc", A_PRESC, 32'h0);
    idle(1);

    // Decode / register access table
    for (int i = 0; i < 17; i++) begin
      bus.addr  = tbl[i].addr;
      bus.wdata = tbl[i].wdata;
      bus.MemRd = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_rdata", i), bus.rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_hit", i), 32'(bus.hit), 32'(tbl[i].exp_hit));
      bus.MemWr = tbl[i].wr;
      @(posedge clk);
      #1;
      bus.MemWr = 1'b0;
      bus.MemRd = 1'b0;
    end
    chk("tbl_irq_clr", 32'(IRQsig), 32'h0);

    // Prescale: tick every 4 cycles, 12 cycles -> 3 increments
    wr(A_PRESC, 32'd3);
    wr(A_TL, 32'd0);
    wr(A_TCON, 32'h1);
    idle(12);
    chk_rd("presc_tl", A_TL, 32'd3);
    chk("presc_irq", 32'(IRQsig), 32'h0);

    // Rewriting PRESC restarts the divider
    wr(A_TCON, 32'h0);
    wr(A_TL, 32'd0);
    wr(A_TCON, 32'h1);
    idle(2);
    wr(A_PRESC, 32'd3);
    idle(3);
    chk_rd("pclr_tl0", A_TL, 32'd0);
    idle(1);
    chk_rd("pclr_tl1", A_TL, 32'd1);

    // Overflow / reload
    wr(A_TCON, 32'h0);
    wr(A_PRESC, 32'd0);
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    idle(1);
    chk_rd("ovf_tl1", A_TL, 32'hFFFF_FFFF);
    chk("ovf_irq1", 32'(IRQsig), 32'h0);
    idle(1);
    chk_rd("ovf_tl2", A_TL, 32'hFFFF_FFF0);
    chk_rd("ovf_tcon2", A_TCON, 32'h7);
    idle(1);
    chk("ovf_irq3", 32'(IRQsig), 32'h1);
    chk_rd("ovf_tl3", A_TL, 32'hFFFF_FFF1);

    // IRQ clear, counting continues
    wr(A_TCON, 32'h3);
    chk("clr_irq", 32'(IRQsig), 32'h0);
    chk_rd("clr_tl", A_TL, 32'hFFFF_FFF2);
    chk_rd("clr_tcon", A_TCON, 32'h3);
    wr(A_TCON, 32'h1);
    idle(13);
    chk_rd("noie_tl", A_TL, 32'hFFFF_FFF0);
    chk_rd("noie_tcon", A_TCON, 32'h1);
    chk("noie_irq", 32'(IRQsig), 32'h0);

    // TCON store on the overflow edge
    idle(15);
    chk_rd("col_tl_pre", A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    chk_rd("col_tcon", A_TCON, 32'h7);
    chk_rd("col_tl", A_TL, 32'hFFFF_FFF0);
    chk("col_irq", 32'(IRQsig), 32'h1);

    // TL store on a tick edge that would otherwise overflow
    wr(A_TCON, 32'h3);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TL, 32'h10);
    chk_rd("tlcol_tl", A_TL, 32'h10);
    chk_rd("tlcol_tcon", A_TCON, 32'h3);
    chk("tlcol_irq", 32'(IRQsig), 32'h0);

    // TH store on the overflow edge reloads the old TH
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h55);
    chk_rd("thcol_tl", A_TL, 32'hFFFF_FFF0);
    chk_rd("thcol_th", A_TH, 32'h55);
    chk("thcol_irq", 32'(IRQsig), 32'h1);

    // Asynchronous reset mid-count
    wr(A_TCON, 32'h0);
    wr(A_PRESC, 32'd3);
    wr(A_TL, 32'd5);
    wr(A_TCON, 32'h7);
    chk("mid_irq", 32'(IRQsig), 32'h1);
    idle(4);
    chk_rd("mid_tl", A_TL, 32'd6);
    #1 reset = 1'b0;
    #1;
    chk("arst_irq", 32'(IRQsig), 32'h0);
    chk_rd("arst_tl", A_TL, 32'h0);
    chk_rd("arst_tcon", A_TCON, 32'h0);
    chk_rd("arst_presc", A_PRESC, 32'h0);
    reset = 1'b1;
    idle(3);
    chk_rd("post_tl", A_TL, 32'h0);
    chk_rd("post_th", A_TH, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
